// File: rtl/ram_arbiter_ctrl.sv
// Two-port round-robin front end for a single-port sync RAM.
// Sequences direct and pointer-indirect accesses.
module ram_arbiter_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic                  ind0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic                  ind1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic                  busy
);

  localparam int HW = ADDR_WIDTH - DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE, PTR_LO, PTR_HI, ACC, DONE
  } state_t;

  state_t                 state;
  logic                   last_grant;
  logic                   gid;
  logic                   l_we;
  logic                   l_ind;
  logic [ADDR_WIDTH-1:0]  l_addr;
  logic [DATA_WIDTH-1:0]  l_wdata;
  logic [DATA_WIDTH-1:0]  ptr_lo;
  logic [HW-1:0]          ptr_hi;
  logic                   gnt1;
  logic                   sel_we;
  logic                   sel_ind;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;

  // port 1 wins alone, or on a tie when port 0 went last
  assign gnt1      = req1 & (~req0 | ~last_grant);
  assign sel_we    = gnt1 ? we1    : we0;
  assign sel_ind   = gnt1 ? ind1   : ind0;
  assign sel_addr  = gnt1 ? addr1  : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gid        <= 1'b0;
      l_we       <= 1'b0;
      l_ind      <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= '0;
      ptr_lo     <= '0;
      ptr_hi     <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            gid        <= gnt1;
            last_grant <= gnt1;
            l_we       <= sel_we;
            l_ind      <= sel_ind;
            l_addr     <= sel_addr;
            l_wdata    <= sel_wdata;
            state      <= sel_ind ? PTR_LO : ACC;
          end
        end
        PTR_LO: begin
          ptr_lo <= ram_din;
          state  <= PTR_HI;
        end
        PTR_HI: begin
          ptr_hi <= ram_din[HW-1:0];
          state  <= ACC;
        end
        ACC: begin
          if (!l_we) begin
            if (gid) rdata1 <= ram_din;
            else     rdata0 <= ram_din;
          end
          ack0  <= ~gid;
          ack1  <= gid;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM side depends only on registered state and latched request
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_oe    = 1'b0;
    unique case (state)
      PTR_LO: begin
        ram_addr = l_addr;
        ram_cs   = 1'b1;
        ram_oe   = 1'b1;
      end
      PTR_HI: begin
        ram_addr = l_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        ram_cs   = 1'b1;
        ram_oe   = 1'b1;
      end
      ACC: begin
        ram_addr  = l_ind ? {ptr_hi, ptr_lo} : l_addr;
        ram_cs    = 1'b1;
        ram_we    = l_we;
        ram_oe    = ~l_we;
        ram_wdata = l_we ? l_wdata : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ram_arbiter_ctrl.md
Name: ram_arbiter_ctrl

Overview:
- Shares one single-port synchronous RAM (8-bit data, 12-bit address; write on posedge, read captured at negedge) between two requesters, e.g. fetch and load/store.
- Round-robin arbitration; sequences each granted access.
- Resolves indirect accesses in hardware: reads a 2-byte pointer from RAM, then accesses the pointed-to location.
- Sits between the CPU datapath and the RAM; the top level ties the RAM tristate data bus to ram_wdata/ram_din.

Parameters:
- ADDR_WIDTH, 12, RAM address width; constraint DATA_WIDTH < ADDR_WIDTH <= 2*DATA_WIDTH.
- DATA_WIDTH, 8, RAM data width.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request, held high until ack0.
- we0  in  1  port 0 write (1) / read (0).
- ind0  in  1  port 0 indirect access.
- addr0  in  ADDR_WIDTH  port 0 address (pointer location if ind0).
- wdata0  in  DATA_WIDTH  port 0 write data.
- ack0  out  1  one-cycle completion pulse, port 0.
- rdata0  out  DATA_WIDTH  port 0 read data, valid when ack0 and held until next port 0 read completes.
- req1, we1, ind1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  data driven onto the RAM bus while ram_cs & ram_we.
- ram_din  in  DATA_WIDTH  RAM bus read value.
- ram_cs, ram_we, ram_oe  out  1 each  RAM chip select, write enable, output enable.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, PTR_LO, PTR_HI, ACC, DONE.
- RAM outputs are decoded from the registered state and latched request only. No combinational path from req*/addr* to ram_*.
- IDLE: ram_cs=ram_we=ram_oe=0.
  - req* sampled only here.
  - On a grant, latch we/ind/addr/wdata and the grant id.
  - Next state is PTR_LO if ind, else ACC.
- Arbitration:
  - Only one requesting: grant it.
  - Both requesting: grant the port not granted last.
  - last_grant resets to 1, so port 0 wins the first tie.
  - last_grant updates on every grant.
- PTR_LO: read cycle (cs=1, oe=1, we=0) at latched addr; ram_din captured into ptr_lo at the end of the cycle.
- PTR_HI: read cycle at addr+1, wrapping modulo 2^ADDR_WIDTH (0xFFF+1 -> 0x000); ram_din captured into ptr_hi.
- Effective address:
  - Indirect: {ptr_hi[ADDR_WIDTH-DATA_WIDTH-1:0], ptr_lo} (12/8: {hi[3:0], lo}); upper pointer bits ignored.
  - Direct: latched addr.
- ACC, one cycle at the effective address:
  - Write: cs=1, we=1, oe=0, ram_wdata=latched wdata; the RAM commits at the closing posedge.
  - Read: cs=1, oe=1, we=0; ram_din captured into the granted port's rdata at the closing posedge.
- DONE: ack of the granted port high for exactly one cycle; RAM idle; next state IDLE.
- Latency, counting the cycle req is seen in IDLE as cycle 0:
  - Direct: ACC in cycle 1, ack in cycle 2.
  - Indirect: PTR_LO 1, PTR_HI 2, ACC 3, ack in cycle 4.
  - A held req is re-sampled in the IDLE cycle after DONE. Back-to-back direct throughput is one access per 3 cycles.
- Requester changes to we/ind/addr/wdata after grant are ignored until the next grant.
- ack0 and ack1 are never high together; at most one RAM access per cycle.
- Reset, including mid-operation, takes effect at the next posedge:
  - state=IDLE, last_grant=1, ack0=ack1=0, rdata0=rdata1=0, ptr regs=0.
  - ram_cs=ram_we=ram_oe=0, ram_addr=0, ram_wdata=0, busy=0.
  - An in-flight transaction is dropped with no ack. A write whose ACC cycle coincides with the reset edge may commit.

Test Plan:
- Reset, then req0 direct read at addr 0x010 holding 0x5A -> ram_cs/oe high in cycle 1 with ram_addr=0x010; ack0 in cycle 2; rdata0=0x5A; busy high in cycles 1-2.
- req1 direct write addr 0x3FF, wdata 0xC3, then read back -> cycle-1 ram_we=1, ram_addr=0x3FF, ram_wdata=0xC3; read returns 0xC3.
- Indirect read, port 0: mem[0x020]=0x34, mem[0x021]=0xF1, mem[0x134]=0x77 -> ram_addr 0x020, 0x021, 0x134 in cycles 1-3; ack0 in cycle 4; rdata0=0x77.
- Pointer wrap: indirect write on port 1 with addr 0xFFF, mem[0xFFF]=0x08, mem[0x000]=0x02, wdata 0x99 -> PTR_HI reads 0x000; mem[0x208]=0x99 afterwards.
- req0 and req1 both held high continuously from reset -> grants alternate 0,1,0,1; acks never overlap; each ack is separated by 3 cycles.
- rst asserted during PTR_HI of an indirect read -> next cycle IDLE with all RAM controls 0; no ack; rdata unchanged at 0; a subsequent request completes normally.
